// File: rtl/cfar_scan_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfar_scan_if : window-request bus between scan scheduler and CFAR datapath
// Revision 1.0
// ---------------------------------------------------------------------------
interface cfar_scan_if #(
    parameter int IDX_W = 12,
    parameter int FRM_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] row_idx;
    logic [IDX_W-1:0] col_idx;
    logic [IDX_W-1:0] row_lo;
    logic [IDX_W-1:0] row_hi;
    logic             last_col;
    logic             last_row;
    logic [FRM_W-1:0] frame_idx;

    modport master (
        output req_valid, row_idx, col_idx, row_lo, row_hi,
               last_col, last_row, frame_idx,
        input  req_ready
    );

    modport slave (
        input  req_valid, row_idx, col_idx, row_lo, row_hi,
               last_col, last_row, frame_idx,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/cfar_scan_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cfar_scan_scheduler : sequences 5x2 CFAR window requests over image frames
// Revision 1.0
// ---------------------------------------------------------------------------
module cfar_scan_scheduler #(
    parameter int IMG_ROWS = 2048,
    parameter int IMG_COLS = 2048,
    parameter int IDX_W    = 12,
    parameter int FRM_W    = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start_i,
    input  wire logic             abort_i,
    input  wire logic [IDX_W-1:0] cfg_rows_i,
    input  wire logic [IDX_W-1:0] cfg_cols_i,
    input  wire logic [FRM_W-1:0] cfg_frames_i,
    input  wire logic [7:0]       cfg_gap_i,
    cfar_scan_if.master           req,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cfg_err_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [IDX_W-1:0] C_MIN_ROWS = IDX_W'(5);
    localparam logic [IDX_W-1:0] C_MIN_COLS = IDX_W'(2);
    localparam logic [IDX_W-1:0] C_ONE      = IDX_W'(1);
    localparam logic [IDX_W-1:0] C_TWO      = IDX_W'(2);
    localparam logic [IDX_W:0]   C_MAX_ROWS = (IDX_W+1)'(IMG_ROWS);
    localparam logic [IDX_W:0]   C_MAX_COLS = (IDX_W+1)'(IMG_COLS);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] rows_q, cols_q;
    logic [FRM_W-1:0] frames_q;
    logic [7:0]       gap_q, gap_cnt_q;
    logic [IDX_W-1:0] row_q, col_q, row_lo_q, row_hi_q;
    logic [IDX_W-1:0] row_d, col_d, row_lo_d, row_hi_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    logic             last_col_q, last_row_q, last_col_d, last_row_d;
    logic             cfg_err_q;

    logic             w_start, w_cfg_bad, w_load, w_hs, w_frm_end, w_final, w_upd;
    logic [IDX_W-1:0] w_rows_src, w_cols_src, w_rows_m1;
    logic [IDX_W:0]   w_row_p2;

    assign w_start   = (state_q == S_IDLE) && start_i && !abort_i;
    assign w_cfg_bad = (cfg_rows_i < C_MIN_ROWS) || (cfg_cols_i < C_MIN_COLS) ||
                       (cfg_frames_i == '0) ||
                       ({1'b0, cfg_rows_i} > C_MAX_ROWS) ||
                       ({1'b0, cfg_cols_i} > C_MAX_COLS);
    assign w_load    = w_start && !w_cfg_bad;
    assign w_hs      = (state_q == S_SCAN) && req.req_ready && !abort_i;
    assign w_frm_end = (frame_q == frames_q - FRM_W'(1));
    assign w_final   = w_hs && last_col_q && last_row_q && w_frm_end;
    assign w_upd     = w_load || (w_hs && !w_final);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (w_load) state_d = S_SCAN;
                S_SCAN: begin
                    if (w_final)
                        state_d = S_DONE;
                    else if (w_hs && last_col_q && (gap_q != 8'd0))
                        state_d = S_GAP;
                end
                S_GAP:  if (gap_cnt_q == 8'd1) state_d = S_SCAN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        req.req_valid = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        case (state_q)
            S_SCAN: begin req.req_valid = 1'b1; busy_o = 1'b1; end
            S_GAP:  busy_o = 1'b1;
            S_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    // Next indices; the final handshake of a run leaves them on the last window.
    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        frame_d    = frame_q;
        w_rows_src = rows_q;
        w_cols_src = cols_q;
        if (w_load) begin
            row_d      = '0;
            col_d      = '0;
            frame_d    = '0;
            w_rows_src = cfg_rows_i;
            w_cols_src = cfg_cols_i;
        end else if (w_hs && !w_final) begin
            if (!last_col_q) begin
                col_d = col_q + C_ONE;
            end else begin
                col_d = '0;
                if (!last_row_q) begin
                    row_d = row_q + C_ONE;
                end else begin
                    row_d   = '0;
                    frame_d = frame_q + FRM_W'(1);
                end
            end
        end
        w_rows_m1  = w_rows_src - C_ONE;
        w_row_p2   = {1'b0, row_d} + (IDX_W+1)'(2);
        row_lo_d   = (row_d >= C_TWO) ? (row_d - C_TWO) : '0;
        row_hi_d   = (w_row_p2 > {1'b0, w_rows_m1}) ? w_rows_m1 : w_row_p2[IDX_W-1:0];
        last_col_d = (col_d == w_cols_src - C_TWO);
        last_row_d = (row_d == w_rows_m1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q     <= '0;
            cols_q     <= '0;
            frames_q   <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            frame_q    <= '0;
            row_lo_q   <= '0;
            row_hi_q   <= '0;
            last_col_q <= 1'b0;
            last_row_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= w_start && w_cfg_bad;
            if (w_start) begin
                rows_q   <= cfg_rows_i;
                cols_q   <= cfg_cols_i;
                frames_q <= cfg_frames_i;
                gap_q    <= cfg_gap_i;
            end
            if (state_q == S_SCAN && state_d == S_GAP)
                gap_cnt_q <= gap_q;
            else if (state_q == S_GAP)
                gap_cnt_q <= gap_cnt_q - 8'd1;
            if (w_upd) begin
                row_q      <= row_d;
                col_q      <= col_d;
                frame_q    <= frame_d;
                row_lo_q   <= row_lo_d;
                row_hi_q   <= row_hi_d;
                last_col_q <= last_col_d;
                last_row_q <= last_row_d;
            end
        end
    end

    assign req.row_idx   = row_q;
    assign req.col_idx   = col_q;
    assign req.row_lo    = row_lo_q;
    assign req.row_hi    = row_hi_q;
    assign req.last_col  = last_col_q;
    assign req.last_row  = last_row_q;
    assign req.frame_idx = frame_q;
    assign cfg_err_o     = cfg_err_q;
endmodule
`default_nettype wire

// File: tb/tb_cfar_scan_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cfar_scan_scheduler : randomized scenario bench with a loop-nest scan model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cfar_scan_scheduler;
    localparam int IDX_W = 12;
    localparam int FRM_W = 8;

    typedef struct packed {
        logic [FRM_W-1:0] f;
        logic [IDX_W-1:0] r;
        logic [IDX_W-1:0] c;
        logic [IDX_W-1:0] lo;
        logic [IDX_W-1:0] hi;
        logic             lc;
        logic             lr;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [IDX_W-1:0] cfg_rows = '0;
    logic [IDX_W-1:0] cfg_cols = '0;
    logic [FRM_W-1:0] cfg_frames = '0;
    logic [7:0]       cfg_gap = '0;
    logic busy, done, cfg_err;

    int tests_run = 0;
    int tests_failed = 0;

    obs_t hs_q[$];
    obs_t exp_q[$];
    int   gaps_q[$];
    int   done_cnt, done_cycle, busy_at_done, first_valid, stall_changes, timeout;

    cfar_scan_if #(.IDX_W(IDX_W), .FRM_W(FRM_W)) bus ();

    cfar_scan_scheduler #(
        .IMG_ROWS(2048), .IMG_COLS(2048), .IDX_W(IDX_W), .FRM_W(FRM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols),
        .cfg_frames_i(cfg_frames), .cfg_gap_i(cfg_gap),
        .req(bus), .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.f = bus.frame_idx; o.r = bus.row_idx; o.c = bus.col_idx;
        o.lo = bus.row_lo; o.hi = bus.row_hi; o.lc = bus.last_col; o.lr = bus.last_row;
        return o;
    endfunction

    function automatic obs_t model(int f, int r, int c, int rows, int cols);
        obs_t o;
        o.f  = FRM_W'(f);
        o.r  = IDX_W'(r);
        o.c  = IDX_W'(c);
        o.lo = IDX_W'((r >= 2) ? r - 2 : 0);
        o.hi = IDX_W'((r + 2 > rows - 1) ? rows - 1 : r + 2);
        o.lc = (c == cols - 2);
        o.lr = (r == rows - 1);
        return o;
    endfunction

    task automatic build_expected(input int rows, input int cols, input int frames);
        exp_q.delete();
        for (int f = 0; f < frames; f++)
            for (int r = 0; r < rows; r++)
                for (int c = 0; c <= cols - 2; c++)
                    exp_q.push_back(model(f, r, c, rows, cols));
    endtask

    // Starts one run and records handshakes, gaps, stalls and done pulses.
    task automatic collect(input int rows, input int cols, input int frames,
                           input int gap, input int ready_pct, input bit scramble);
        obs_t cur, prev;
        bit   prev_stall;
        int   cyc, budget, gap_run;
        hs_q.delete(); gaps_q.delete();
        done_cnt = 0; done_cycle = -1; busy_at_done = 1; first_valid = -1;
        stall_changes = 0; timeout = 0;
        budget = 200 + frames * rows * (cols - 1) * 30 + frames * rows * gap;
        @(negedge clk);
        cfg_rows = IDX_W'(rows); cfg_cols = IDX_W'(cols);
        cfg_frames = FRM_W'(frames); cfg_gap = 8'(gap);
        start = 1'b1;
        cyc = 0; prev_stall = 1'b0; gap_run = 0; prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            start = (scramble && cyc == 3);
            if (scramble && cyc == 1) begin
                cfg_rows = 12'd7; cfg_cols = 12'd9; cfg_frames = 8'd3; cfg_gap = 8'd5;
            end
            cur = sample();
            if (bus.req_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && (!bus.req_valid || cur !== prev)) stall_changes++;
            if (busy && !bus.req_valid) gap_run++;
            else if (bus.req_valid && gap_run > 0) begin
                gaps_q.push_back(gap_run);
                gap_run = 0;
            end
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) begin done_cycle = cyc; busy_at_done = busy; end
            end
            bus.req_ready = ($urandom_range(0, 99) < ready_pct);
            if (bus.req_valid && bus.req_ready) hs_q.push_back(cur);
            prev_stall = bus.req_valid && !bus.req_ready;
            prev = cur;
            if (done_cycle >= 0 && cyc >= done_cycle + 3) break;
            if (cyc >= budget) begin timeout = 1; break; end
        end
        start = 1'b0;
        bus.req_ready = 1'b0;
    endtask

    task automatic test_reset();
        obs_t cur;
        #12;
        cur = sample();
        tests_run++;
        if (cur !== obs_t'(0) || bus.req_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || cfg_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got idx=%h v=%b busy=%b done=%b err=%b want all 0",
                     cur, bus.req_valid, busy, done, cfg_err);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.req_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle got v=%b busy=%b want 0 0", bus.req_valid, busy);
        end
        // Reset in the middle of a run.
        cfg_rows = 12'd5; cfg_cols = 12'd4; cfg_frames = 8'd1; cfg_gap = 8'd0;
        start = 1'b1;
        @(negedge clk); start = 1'b0; bus.req_ready = 1'b1;
        repeat (4) @(negedge clk);
        cur = sample();
        tests_run++;
        if (bus.req_valid !== 1'b1 || cur !== model(0, 1, 1, 5, 4)) begin
            tests_failed++;
            $display("FAIL midrun_pos got v=%b idx=%h want 1 %h", bus.req_valid, cur,
                     model(0, 1, 1, 5, 4));
        end
        #2 rst_n = 1'b0;
        #1;
        cur = sample();
        tests_run++;
        if (cur !== obs_t'(0) || bus.req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset got idx=%h v=%b busy=%b done=%b want all 0",
                     cur, bus.req_valid, busy, done);
        end
        bus.req_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        build_expected(5, 4, 1);
        collect(5, 4, 1, 0, 100, 1'b0);
        tests_run++;
        if (timeout !== 0 || hs_q.size() !== 15) begin
            tests_failed++;
            $display("FAIL basic_count got %0d hs timeout=%0d want 15 0", hs_q.size(), timeout);
        end
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
            tests_run++;
            if (hs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL basic_hs[%0d] got %h want %h", i, hs_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (first_valid !== 1 || done_cycle !== 16 || done_cnt !== 1 || busy_at_done !== 0) begin
            tests_failed++;
            $display("FAIL basic_timing got first=%0d done_at=%0d dones=%0d busy=%0d want 1 16 1 0",
                     first_valid, done_cycle, done_cnt, busy_at_done);
        end
        tests_run++;
        if (gaps_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL basic_gaps got %0d gaps want 0", gaps_q.size());
        end
    endtask

    task automatic test_stall();
        build_expected(5, 4, 1);
        collect(5, 4, 1, 0, 50, 1'b1);
        tests_run++;
        if (timeout !== 0 || hs_q.size() !== 15 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL stall_count got %0d hs dones=%0d timeout=%0d want 15 1 0",
                     hs_q.size(), done_cnt, timeout);
        end
        tests_run++;
        if (stall_changes !== 0) begin
            tests_failed++;
            $display("FAIL stall_hold got %0d changes while stalled want 0", stall_changes);
        end
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
            tests_run++;
            if (hs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL stall_hs[%0d] got %h want %h", i, hs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gap();
        build_expected(5, 3, 1);
        collect(5, 3, 1, 3, 100, 1'b0);
        tests_run++;
        if (timeout !== 0 || hs_q.size() !== 10 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL gap_count got %0d hs dones=%0d timeout=%0d want 10 1 0",
                     hs_q.size(), done_cnt, timeout);
        end
        tests_run++;
        if (gaps_q.size() !== 4) begin
            tests_failed++;
            $display("FAIL gap_runs got %0d gaps want 4", gaps_q.size());
        end
        foreach (gaps_q[i]) begin
            tests_run++;
            if (gaps_q[i] !== 3) begin
                tests_failed++;
                $display("FAIL gap_len[%0d] got %0d want 3", i, gaps_q[i]);
            end
        end
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
            tests_run++;
            if (hs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL gap_hs[%0d] got %h want %h", i, hs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_multi_frame();
        build_expected(5, 4, 2);
        collect(5, 4, 2, 0, 100, 1'b0);
        tests_run++;
        if (timeout !== 0 || hs_q.size() !== 30 || done_cnt !== 1 || done_cycle !== 31) begin
            tests_failed++;
            $display("FAIL frames_count got %0d hs dones=%0d done_at=%0d want 30 1 31",
                     hs_q.size(), done_cnt, done_cycle);
        end
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
            tests_run++;
            if (hs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL frames_hs[%0d] got %h want %h", i, hs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int rows, cols, frames, gap, pct, bad;
        for (int it = 0; it < 5; it++) begin
            rows = $urandom_range(5, 9); cols = $urandom_range(2, 6);
            frames = $urandom_range(1, 2); gap = $urandom_range(0, 3);
            pct = $urandom_range(30, 100);
            build_expected(rows, cols, frames);
            collect(rows, cols, frames, gap, pct, 1'b0);
            tests_run++;
            if (timeout !== 0 || hs_q.size() !== exp_q.size() || done_cnt !== 1 ||
                stall_changes !== 0) begin
                tests_failed++;
                $display("FAIL rand%0d_run got hs=%0d dones=%0d stalls=%0d timeout=%0d want %0d 1 0 0",
                         it, hs_q.size(), done_cnt, stall_changes, timeout, exp_q.size());
            end
            bad = 0;
            for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
                if (hs_q[i] !== exp_q[i]) bad++;
            foreach (gaps_q[i]) if (gaps_q[i] !== gap) bad++;
            if (gaps_q.size() !== ((gap > 0) ? frames * rows - 1 : 0)) bad++;
            tests_run++;
            if (bad !== 0) begin
                tests_failed++;
                $display("FAIL rand%0d_seq r=%0d c=%0d f=%0d g=%0d got %0d bad items want 0",
                         it, rows, cols, frames, gap, bad);
            end
        end
    endtask

    task automatic test_cfg_err();
        int tbl_rows[4] = '{4, 5, 5, 5};
        int tbl_cols[4] = '{4, 1, 3000, 4};
        int tbl_frm[4]  = '{0, 1, 1, 0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cfg_rows = IDX_W'(tbl_rows[k]); cfg_cols = IDX_W'(tbl_cols[k]);
            cfg_frames = FRM_W'(tbl_frm[k]); cfg_gap = 8'd0;
            start = 1'b1;
            @(negedge clk); start = 1'b0;
            tests_run++;
            if (cfg_err !== 1'b1 || bus.req_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL cfg_err%0d_pulse got err=%b v=%b busy=%b want 1 0 0",
                         k, cfg_err, bus.req_valid, busy);
            end
            @(negedge clk);
            tests_run++;
            if (cfg_err !== 1'b0 || bus.req_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL cfg_err%0d_after got err=%b v=%b busy=%b want 0 0 0",
                         k, cfg_err, bus.req_valid, busy);
            end
        end
        build_expected(5, 4, 1);
        collect(5, 4, 1, 0, 100, 1'b0);
        tests_run++;
        if (timeout !== 0 || hs_q.size() !== 15 || done_cnt !== 1 ||
            (hs_q.size() > 0 && hs_q[0] !== exp_q[0])) begin
            tests_failed++;
            $display("FAIL cfg_err_recover got hs=%0d dones=%0d timeout=%0d want 15 1 0",
                     hs_q.size(), done_cnt, timeout);
        end
    endtask

    task automatic test_abort();
        obs_t cur;
        bit   found = 1'b0;
        int   dones = 0, valids = 0;
        @(negedge clk);
        cfg_rows = 12'd5; cfg_cols = 12'd4; cfg_frames = 8'd1; cfg_gap = 8'd0;
        start = 1'b1;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            cur = sample();
            if (bus.req_valid && cur.r == 2 && cur.c == 1) begin
                found = 1'b1;
                bus.req_ready = 1'b0;
                abort = 1'b1;
            end else begin
                bus.req_ready = 1'b1;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL abort_reach got no (2,1) request within 40 cycles want one");
        end
        @(negedge clk);
        abort = 1'b0; bus.req_ready = 1'b1;
        tests_run++;
        if (bus.req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle got v=%b busy=%b done=%b want 0 0 0",
                     bus.req_valid, busy, done);
        end
        repeat (10) begin
            @(negedge clk);
            if (done) dones++;
            if (bus.req_valid) valids++;
        end
        tests_run++;
        if (dones !== 0 || valids !== 0) begin
            tests_failed++;
            $display("FAIL abort_quiet got dones=%0d valids=%0d want 0 0", dones, valids);
        end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        tests_run++;
        if (bus.req_valid !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_abort got v=%b busy=%b err=%b want 0 0 0",
                     bus.req_valid, busy, cfg_err);
        end
        @(negedge clk);
        tests_run++;
        if (bus.req_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_abort_hold got v=%b busy=%b want 0 0", bus.req_valid, busy);
        end
        bus.req_ready = 1'b0;
        build_expected(5, 4, 1);
        collect(5, 4, 1, 0, 100, 1'b0);
        tests_run++;
        if (timeout !== 0 || hs_q.size() !== 15 || done_cnt !== 1 ||
            (hs_q.size() > 0 && hs_q[0] !== exp_q[0])) begin
            tests_failed++;
            $display("FAIL abort_restart got hs=%0d first=%h dones=%0d want 15 %h 1",
                     hs_q.size(), (hs_q.size() > 0) ? hs_q[0] : obs_t'(0), done_cnt, exp_q[0]);
        end
    endtask

    initial begin
        bus.req_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_gap();
        test_multi_frame();
        test_cfg_err();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
